controlador_ring: RTL
=====================

CONTROLADOR_RING -- requirements
Module: controlador_ring

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 30: frames per ON phase and per OFF phase of the ring-ball blink (valid range 1..63).
REQ-002 SHALL have parameter MAX_BLINKS, default 20: number of full ON+OFF cycles before timeout (valid range 1..31).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port p_tick, input, 1 bit: pixel-rate enable from the VGA sync block.
REQ-006 SHALL have port pixel_x, input, 10 bits: current VGA column.
REQ-007 SHALL have port pixel_y, input, 10 bits: current VGA row.
REQ-008 SHALL have port ring_req, input, 1 bit: level alarm request from the timer comparator.
REQ-009 SHALL have port ring_ack, input, 1 bit: one-cycle debounced user acknowledge pulse.
REQ-010 SHALL have port ring_en, output, 1 bit: gates pic_ring_on of the image generator.
REQ-011 SHALL have port ringball_en, output, 1 bit: gates pic_ringball_on of the image generator.
REQ-012 SHALL have port ring_active, output, 1 bit: alarm is sounding (ON or OFF state).
REQ-013 SHALL have port ring_timeout, output, 1 bit: alarm ended unacknowledged.

Function
REQ-014 SHALL generate frame_tick, a registered one-cycle pulse, when p_tick=1 and pixel_x=0 and pixel_y=0.
REQ-015 SHALL register ring_req and detect its rising edge (req_rise); a level held high SHALL NOT re-trigger.
REQ-016 SHALL implement the FSM states IDLE, ON, OFF, TIMEOUT.
REQ-017 IDLE: on req_rise go to ON and clear frame_cnt and blink_cnt; ring_ack is ignored.
REQ-018 ON: count frame_ticks; on the tick that makes frame_cnt=BLINK_FRAMES, clear frame_cnt and go to OFF.
REQ-019 OFF: count frame_ticks the same way; at BLINK_FRAMES, if blink_cnt=MAX_BLINKS-1 go to TIMEOUT, else increment blink_cnt and go to ON.
REQ-020 ON/OFF: ring_ack=1 SHALL go to IDLE next cycle, with priority over a simultaneous frame_tick.
REQ-021 TIMEOUT: go to IDLE on ring_ack=1 or on registered ring_req=0.
REQ-022 A req_rise in ON, OFF or TIMEOUT SHALL be ignored; there is no restart while busy.
REQ-023 Outputs SHALL be registered Moore outputs, valid in the cycle after the state is entered:
- IDLE: all 0.
- ON: ring_en=1, ringball_en=1, ring_active=1.
- OFF: ring_en=1, ringball_en=0, ring_active=1.
- TIMEOUT: ring_en=1, ring_timeout=1, others 0.
REQ-024 frame_cnt SHALL be 6 bits and blink_cnt 5 bits, unsigned; neither SHALL wrap within a legal run.
REQ-025 Frame counting SHALL advance only on frame_tick and never on plain clk cycles.

Reset
REQ-026 reset=1 SHALL immediately force: state IDLE; frame_cnt, blink_cnt, ring_req register and frame_tick to 0; all outputs to 0.
REQ-027 Reset asserted mid-alarm SHALL abort the alarm; after release, a new req_rise is needed, even if ring_req is still high (the register restarts at 0, so one rise is seen).

Structure
REQ-028 The FSM state encodings (2 bits) and the frame-tick coordinates (0,0) SHALL live in the shared project include file used by the VGA blocks.
REQ-029 Frame-tick detection SHALL be the sub-module detector_frame (inputs clk, reset, p_tick, pixel_x, pixel_y; output frame_tick).
REQ-030 ring_en/ringball_en SHALL be ANDed with the generator's pic_ring_on/pic_ringball_on at the top level, with no change to the generator.

Verification (BLINK_FRAMES=2, MAX_BLINKS=3, frame_tick forced every 10 clk)
REQ-031 Raise ring_req, hold high -> ON; ringball_en toggles 1,0 every 2 frames; TIMEOUT after 12 frames; ring_timeout=1, ring_en=1.
REQ-032 In TIMEOUT drop ring_req -> IDLE next cycle; raise it again -> new alarm starts with blink_cnt=0.
REQ-033 ring_ack in the same cycle as the frame_tick ending an ON phase -> IDLE, not OFF; all outputs 0 one cycle later.
REQ-034 Assert reset during OFF with ring_req held high -> outputs 0 at once; after release one req_rise is seen and the alarm restarts in ON.
REQ-035 Pulse ring_ack in IDLE, and raise ring_req again while in ON -> no state change in either case.
REQ-036 Real p_tick sweep of a 800x525 frame -> exactly one frame_tick per frame, at pixel (0,0).

Source files
------------

// File: rtl/controlador_ring_pkg.sv
// Shared definitions for the ring alarm controller: FSM encodings, the frame-tick
// coordinates and the state-to-output decode.
package controlador_ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ON      = 2'd1,
    ST_OFF     = 2'd2,
    ST_TIMEOUT = 2'd3
  } ring_state_e;

  // Pixel whose p_tick marks the start of a new VGA frame
  localparam logic [9:0] FRAME_TICK_X = 10'd0;
  localparam logic [9:0] FRAME_TICK_Y = 10'd0;

  typedef struct packed {
    logic ring_en;
    logic ringball_en;
    logic ring_active;
    logic ring_timeout;
  } ring_out_t;

  function automatic ring_out_t decode_outputs(input ring_state_e s);
    ring_out_t o;
    o = '0;
    case (s)
      ST_ON:      o = '{ring_en: 1'b1, ringball_en: 1'b1, ring_active: 1'b1, ring_timeout: 1'b0};
      ST_OFF:     o = '{ring_en: 1'b1, ringball_en: 1'b0, ring_active: 1'b1, ring_timeout: 1'b0};
      ST_TIMEOUT: o = '{ring_en: 1'b1, ringball_en: 1'b0, ring_active: 1'b0, ring_timeout: 1'b1};
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/controlador_ring_detector_frame.sv
// Registered one-cycle frame_tick on the pixel-rate enable at the frame origin.
module detector_frame
  import controlador_ring_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       frame_tick
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= p_tick && (pixel_x == FRAME_TICK_X) && (pixel_y == FRAME_TICK_Y);
  end

endmodule

// File: rtl/controlador_ring.sv
// Alarm ring controller: blinks the ring ball ON/OFF per frame count, times out
// after MAX_BLINKS cycles, and is cleared by a user acknowledge.
module controlador_ring
  import controlador_ring_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int MAX_BLINKS   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       ring_req,
  input  logic       ring_ack,
  output logic       ring_en,
  output logic       ringball_en,
  output logic       ring_active,
  output logic       ring_timeout
);

  localparam logic [5:0] FRAME_LAST = 6'(BLINK_FRAMES - 1);
  localparam logic [4:0] BLINK_LAST = 5'(MAX_BLINKS - 1);

  logic        frame_tick;
  logic        req_q;
  logic        req_rise;
  ring_state_e state_q, state_d;
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic [4:0]  blink_cnt_q, blink_cnt_d;
  ring_out_t   out_q;

  detector_frame u_det (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick)
  );

  // req_q restarts at 0 after reset, so a held request produces exactly one rise
  assign req_rise = ring_req & ~req_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= 1'b0;
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      out_q       <= '0;
    end else begin
      req_q       <= ring_req;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      out_q       <= decode_outputs(state_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_rise) begin
          state_d     = ST_ON;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
        end
      end
      ST_ON: begin
        if (ring_ack) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            state_d     = ST_OFF;
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
      end
      ST_OFF: begin
        if (ring_ack) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            if (blink_cnt_q == BLINK_LAST) begin
              state_d = ST_TIMEOUT;
            end else begin
              blink_cnt_d = blink_cnt_q + 5'd1;
              state_d     = ST_ON;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
      end
      ST_TIMEOUT: begin
        if (ring_ack || !req_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ring_en      = out_q.ring_en;
  assign ringball_en  = out_q.ringball_en;
  assign ring_active  = out_q.ring_active;
  assign ring_timeout = out_q.ring_timeout;

endmodule
